// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and sequencer state encoding.
// Used by simple_alu, alu_op_sequencer, the reference model and benches.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND    = 4'd0;
  localparam logic [OP_W-1:0] OP_OR     = 4'd1;
  localparam logic [OP_W-1:0] OP_XOR    = 4'd2;
  localparam logic [OP_W-1:0] OP_NOT_A  = 4'd3;
  localparam logic [OP_W-1:0] OP_NOT_B  = 4'd4;
  localparam logic [OP_W-1:0] OP_ADD    = 4'd5;
  localparam logic [OP_W-1:0] OP_SUB    = 4'd6;
  localparam logic [OP_W-1:0] OP_PASS_A = 4'd7;
  localparam logic [OP_W-1:0] OP_PASS_B = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of simple_alu for result self-checking.
// Ports: a_i/b_i operands, op_i opcode, exp_o expected result (0 for
// undefined opcodes).
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] exp_o
);

  always_comb begin
    exp_o = '0;
    case (op_i)
      OP_AND:    exp_o = a_i & b_i;
      OP_OR:     exp_o = a_i | b_i;
      OP_XOR:    exp_o = a_i ^ b_i;
      OP_NOT_A:  exp_o = ~a_i;
      OP_NOT_B:  exp_o = ~b_i;
      OP_ADD:    exp_o = a_i + b_i;
      OP_SUB:    exp_o = a_i - b_i;
      OP_PASS_A: exp_o = a_i;
      OP_PASS_B: exp_o = b_i;
      default:   exp_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sweeps an attached ALU through opcodes 0..NUM_OPS-1 for one latched
// operand pair and streams each settled result out on a valid/ready port.
// Ports: clk/rst_n (sync, active low); start_valid/start_ready with
// a_in/b_in; alu_a/alu_b/alu_sel/alu_result to the ALU; res_valid/
// res_ready/res_op/res_data result stream; busy; done pulse.
// Build option ALU_SEQ_CHECK_EN adds mismatch and err_count (8-bit sat.)
// driven by an internal alu_ref_model.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int NUM_OPS = 9,
  parameter int SETTLE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OP_W-1:0]  res_op,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic             done
`ifdef ALU_SEQ_CHECK_EN
  ,
  output logic             mismatch,
  output logic [7:0]       err_count
`endif
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [OP_W-1:0] OP_LAST  = OP_W'(NUM_OPS - 1);

  seq_state_e       state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [OP_W-1:0]  rop_q, rop_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      rop_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      rop_q   <= rop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    data_d      = data_q;
    rop_d       = rop_q;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    alu_sel     = op_q;
    unique case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        alu_sel     = '0;
        if (start_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          op_d    = '0;
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        // Sample only after the ALU inputs have been stable SETTLE cycles.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          data_d  = alu_result;
          rop_d   = op_q;
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EMIT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (op_q == OP_LAST) begin
            state_d = DONE;
          end else begin
            op_d    = op_q + 1'b1;
            state_d = DRIVE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign res_op   = rop_q;
  assign res_data = data_q;

`ifdef ALU_SEQ_CHECK_EN
  logic [WIDTH-1:0] exp_w;
  logic [7:0]       err_q, err_d;
  logic             start_hs;
  logic             accept;

  alu_ref_model #(
    .WIDTH(WIDTH)
  ) u_ref (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (rop_q),
    .exp_o(exp_w)
  );

  assign start_hs = (state_q == IDLE) && start_valid;
  assign accept   = (state_q == EMIT) && res_ready;
  assign mismatch = (state_q == EMIT) && (data_q != exp_w);

  always_comb begin
    err_d = err_q;
    if (start_hs) begin
      err_d = '0;
    end else if (accept && mismatch && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`endif

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator-side companion to simple_alu. On one start handshake it latches an operand pair, then sweeps alu_sel through every opcode. For each opcode it drives the ALU, waits a settle interval, captures the result and offers it downstream on a valid/ready stream. It is used for ALU bring-up and for self-test sweeps inside larger datapaths.

Parameters:
WIDTH, 1, operand and result width; must match the attached simple_alu.
NUM_OPS, 9, number of opcodes swept (0..NUM_OPS-1); legal range 1..16.
SETTLE, 1, cycles alu_sel/alu_a/alu_b are held before the result is sampled; minimum 1.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
start_valid  input  1  request to begin a sweep.
start_ready  output  1  high only in IDLE.
a_in  input  WIDTH  operand A; captured on start handshake.
b_in  input  WIDTH  operand B; captured on start handshake.
alu_a  output  WIDTH  operand A driven to ALU.
alu_b  output  WIDTH  operand B driven to ALU.
alu_sel  output  4  opcode driven to ALU.
alu_result  input  WIDTH  combinational ALU result.
res_valid  output  1  result beat available.
res_ready  input  1  downstream accepts beat.
res_op  output  4  opcode of current beat.
res_data  output  WIDTH  captured result.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (rst_n low at edge): state IDLE; every output 0 except start_ready=1; the op counter and settle counter clear. The same applies mid-sweep: the in-flight beat is dropped and done is not pulsed.
- FSM states:
  - IDLE: start_valid&&start_ready latches a_in/b_in into alu_a/alu_b, sets op=0, and goes to DRIVE.
  - DRIVE: alu_sel=op. Stays SETTLE cycles. On the last DRIVE cycle, alu_result is registered into res_data, res_op=op, and the FSM goes to EMIT.
  - EMIT: res_valid=1; res_data and res_op are held stable until accepted.
    - On res_ready with op==NUM_OPS-1, go to DONE.
    - Otherwise op++ and go to DRIVE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- alu_a, alu_b and alu_sel hold their values through EMIT and DONE. alu_sel returns to 0 in IDLE. alu_a and alu_b keep their last values.
- Latency with res_ready tied high:
  - res_valid rises SETTLE+1 cycles after the start handshake edge.
  - Each op takes SETTLE+1 cycles.
  - done is asserted NUM_OPS*(SETTLE+1)+1 cycles after the handshake; 19 cycles for the defaults.
- Boundaries:
  - start_valid while busy is ignored.
  - res_ready outside EMIT is ignored.
  - res_ready held low stalls indefinitely in EMIT with outputs frozen.
  - Wrap: op never exceeds NUM_OPS-1.
  - start_valid high in the DONE cycle is not accepted; it is accepted in the following IDLE cycle.

Optional Feature:
Macro ALU_SEQ_CHECK_EN.
- Defined: adds outputs mismatch (1 bit, valid with res_valid) and err_count (8 bits, saturating at 255, cleared by reset and by each start handshake). An internal reference model computes the expected result for op using the latched operands:
  - 0 AND, 1 OR, 2 XOR, 3 NOT A, 4 NOT B
  - 5 ADD, 6 SUB (both truncated to WIDTH)
  - 7 PASS A, 8 PASS B; other opcodes expect 0
  - mismatch=(res_data!=expected) during EMIT.
  - err_count increments once per accepted beat with mismatch.
- Undefined: these ports and the reference logic do not exist; all other behaviour is unchanged.

Decomposition:
- Package alu_pkg holds:
  - the opcode constants (OP_AND=0 … OP_PASS_B=8) and OP_W=4;
  - the FSM state encoding (IDLE, DRIVE, EMIT, DONE).
  simple_alu and its benches share this package.
- One sub-module, alu_ref_model: combinational, WIDTH-parameterized, instantiated only under ALU_SEQ_CHECK_EN.

Test Plan:
1. Defaults, a_in=0, b_in=1, res_ready=1, attached simple_alu -> beats op0..8 carry 0,1,1,1,0,1,1,0,1; done exactly once, 19 cycles after the handshake.
2. res_ready low for 5 cycles on op 3 -> res_valid stays high and res_data/res_op (1/3) stay stable; the sweep resumes on res_ready and the total is extended by 5 cycles.
3. start_valid pulsed during op 4 and again in the DONE cycle -> both ignored; start_ready=0 throughout busy; a new start one cycle after DONE is accepted.
4. rst_n low for 1 cycle during EMIT of op 6 -> next cycle IDLE, res_valid=0, alu_sel=0, start_ready=1, no done pulse.
5. SETTLE=3, a_in=1, b_in=1 -> alu_sel held 3 cycles per op; ADD beat=0 and SUB beat=0 (1-bit truncation).
6. ALU_SEQ_CHECK_EN with the ALU result forced to 0 at op 1 -> mismatch=1 on the op 1 beat only; err_count=1 at done.
